// File: rtl/alu_div_iter.sv
// rtl/alu_div_iter.sv - iterative restoring divider/remainder unit for the EX-stage ALU
module alu_div_iter #(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic             core_clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic [1:0]       operator_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  input  logic             ex_ready_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] result_o,
  output logic             ready_o,
  output logic             busy_o
);

  localparam int ITER = WIDTH / STEPS;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    FINISH
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       op_q;
  logic             negq_q;
  logic             negr_q;
  logic             special_q;

  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             div_zero;
  logic             sgn_ovf;

  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH:0]   r_v;
  logic [WIDTH-1:0] q_v;
  logic [WIDTH+1:0] diff;

  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;

  // Operand conditioning at capture: magnitudes for signed ops and early-out detection on raw operands
  always_comb begin
    sign_a   = operator_i[0] & operand_a_i[WIDTH-1];
    sign_b   = operator_i[0] & operand_b_i[WIDTH-1];
    abs_a    = sign_a ? (-operand_a_i) : operand_a_i;
    abs_b    = sign_b ? (-operand_b_i) : operand_b_i;
    div_zero = (operand_b_i == '0);
    sgn_ovf  = operator_i[0] &&
               (operand_a_i == {1'b1, {(WIDTH-1){1'b0}}}) &&
               (operand_b_i == '1);
  end

  // STEPS restoring steps per cycle; the dividend shifts out of quo_q MSB-first as quotient bits shift in
  always_comb begin
    r_v  = rem_q;
    q_v  = quo_q;
    diff = '0;
    for (int i = 0; i < STEPS; i++) begin
      r_v  = {r_v[WIDTH-1:0], q_v[WIDTH-1]};
      q_v  = {q_v[WIDTH-2:0], 1'b0};
      diff = {1'b0, r_v} - {2'b0, dvs_q};
      if (!diff[WIDTH+1]) begin
        r_v    = diff[WIDTH:0];
        q_v[0] = 1'b1;
      end
    end
    rem_step = r_v;
    quo_step = q_v;
  end

  // State register
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and outputs; flush overrides every other transition
  always_comb begin
    state_d  = state_q;
    ready_o  = 1'b0;
    busy_o   = (state_q != IDLE);
    result_o = '0;
    q_out    = (op_q[0] && negq_q && !special_q) ? (-quo_q) : quo_q;
    r_out    = (op_q[0] && negr_q && !special_q) ? (-rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
    case (state_q)
      IDLE: begin
        if (enable_i) state_d = DIVIDE;
      end
      DIVIDE: begin
        if (cnt_q == CW'(1)) state_d = FINISH;
      end
      FINISH: begin
        ready_o  = 1'b1;
        result_o = op_q[1] ? r_out : q_out;
        if (ex_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // Datapath: capture in IDLE, iterate in DIVIDE; early-out results are preloaded and
  // held for a single DIVIDE cycle so they surface one edge after the accept edge
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      special_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable_i && !flush_i) begin
            op_q      <= operator_i;
            negq_q    <= sign_a ^ sign_b;
            negr_q    <= sign_a;
            dvs_q     <= abs_b;
            special_q <= div_zero | sgn_ovf;
            if (div_zero) begin
              quo_q <= '1;
              rem_q <= {1'b0, operand_a_i};
              cnt_q <= CW'(1);
            end else if (sgn_ovf) begin
              quo_q <= operand_a_i;
              rem_q <= '0;
              cnt_q <= CW'(1);
            end else begin
              quo_q <= abs_a;
              rem_q <= '0;
              cnt_q <= CW'(ITER);
            end
          end
        end
        DIVIDE: begin
          if (!special_q) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
          end
          cnt_q <= cnt_q - CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_iter.sv
// tb/tb_alu_div_iter.sv - self-checking bench for alu_div_iter at STEPS 1, 2 and 4
module tb_alu_div_iter;

  logic core_clk = 1'b0;
  logic rst;

  always #5 core_clk = ~core_clk;

  logic [2:0]        en;
  logic [2:0][1:0]   op;
  logic [2:0][31:0]  a;
  logic [2:0][31:0]  b;
  logic [2:0]        exr;
  logic [2:0]        fl;
  logic [2:0][31:0]  res;
  logic [2:0]        rdy;
  logic [2:0]        bsy;

  logic [31:0] exp_res [3];
  logic [2:0]  exp_v;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    alu_div_iter #(
      .WIDTH(32),
      .STEPS(g == 0 ? 1 : (g == 1 ? 2 : 4))
    ) dut (
      .core_clk    (core_clk),
      .rst         (rst),
      .enable_i    (en[g]),
      .operator_i  (op[g]),
      .operand_a_i (a[g]),
      .operand_b_i (b[g]),
      .ex_ready_i  (exr[g]),
      .flush_i     (fl[g]),
      .result_o    (res[g]),
      .ready_o     (rdy[g]),
      .busy_o      (bsy[g])
    );
  end

  function automatic int steps_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  // Reference: plain 64-bit arithmetic with truncating division, plus the two early-out rules
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb);
    longint sa, sb, q, r;
    logic [63:0] qb, rb;
    if (vb == 32'h0) return o[1] ? va : 32'hFFFF_FFFF;
    if (o[0] && va == 32'h8000_0000 && vb == 32'hFFFF_FFFF) return o[1] ? 32'h0 : va;
    if (o[0]) begin
      sa = longint'($signed(va));
      sb = longint'($signed(vb));
    end else begin
      sa = longint'({32'h0, va});
      sb = longint'({32'h0, vb});
    end
    q  = sa / sb;
    r  = sa % sb;
    qb = q;
    rb = r;
    return o[1] ? rb[31:0] : qb[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  // Every cycle: ready results must match the model; idle units must present zeros
  always @(negedge core_clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rdy[k] && exp_v[k]) chk($sformatf("model_result_u%0d", k), res[k], exp_res[k]);
      if (!bsy[k]) begin
        chk($sformatf("idle_ready_u%0d", k), {31'h0, rdy[k]}, 32'h0);
        chk($sformatf("idle_result_u%0d", k), res[k], 32'h0);
      end
    end
  end

  task automatic run_op(input int k, input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                        input logic use_lit, input logic [31:0] lit, input int hold, input string name);
    int n;
    int exp_lat;
    logic special;
    special = (vb == 32'h0) || (o[0] && va == 32'h8000_0000 && vb == 32'hFFFF_FFFF);
    exp_lat = special ? 1 : 32 / steps_of(k);
    @(negedge core_clk);
    en[k] = 1'b1;
    op[k] = o;
    a[k]  = va;
    b[k]  = vb;
    @(posedge core_clk);
    #1;
    en[k]      = 1'b0;
    exp_res[k] = model(o, va, vb);
    exp_v[k]   = 1'b1;
    op[k]      = 2'($urandom);
    a[k]       = $urandom;
    b[k]       = $urandom;
    chk({name, "_busy"}, {31'h0, bsy[k]}, 32'h1);
    n = 0;
    while (!rdy[k] && n < 100) begin
      @(posedge core_clk);
      #1;
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(exp_lat));
    if (use_lit) chk(name, res[k], lit);
    for (int i = 0; i < hold; i++) begin
      @(negedge core_clk);
      en[k] = ~en[k];
      a[k]  = $urandom;
      b[k]  = $urandom;
      @(posedge core_clk);
      #1;
      chk({name, "_hold_ready"}, {31'h0, rdy[k]}, 32'h1);
      chk({name, "_hold_result"}, res[k], use_lit ? lit : exp_res[k]);
    end
    @(negedge core_clk);
    en[k]  = 1'b0;
    exr[k] = 1'b1;
    @(posedge core_clk);
    #1;
    exr[k]   = 1'b0;
    exp_v[k] = 1'b0;
    chk({name, "_done_busy"}, {31'h0, bsy[k]}, 32'h0);
    chk({name, "_done_ready"}, {31'h0, rdy[k]}, 32'h0);
  endtask

  task automatic start_only(input int k, input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb);
    @(negedge core_clk);
    en[k] = 1'b1;
    op[k] = o;
    a[k]  = va;
    b[k]  = vb;
    @(posedge core_clk);
    #1;
    en[k] = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] va, vb;
    int reps;
    rst   = 1'b1;
    en    = '0;
    op    = '0;
    a     = '0;
    b     = '0;
    exr   = '0;
    fl    = '0;
    exp_v = '0;
    exp_res[0] = '0;
    exp_res[1] = '0;
    exp_res[2] = '0;
    repeat (2) @(posedge core_clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_busy_u%0d", k), {31'h0, bsy[k]}, 32'h0);
      chk($sformatf("reset_ready_u%0d", k), {31'h0, rdy[k]}, 32'h0);
      chk($sformatf("reset_result_u%0d", k), res[k], 32'h0);
    end
    @(negedge core_clk);
    rst = 1'b0;

    run_op(0, 2'b00, 32'd100,        32'd7,          1'b1, 32'd14,          0, "divu_100_7");
    run_op(0, 2'b10, 32'd100,        32'd7,          1'b1, 32'd2,           0, "remu_100_7");
    run_op(0, 2'b01, 32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,   0, "div_m7_2");
    run_op(0, 2'b11, 32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFF,   0, "rem_m7_2");
    run_op(0, 2'b01, 32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,   0, "div_7_m2");
    run_op(0, 2'b01, 32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,   0, "div_5_0");
    run_op(0, 2'b10, 32'd5,          32'd0,          1'b1, 32'd5,           0, "remu_5_0");
    run_op(0, 2'b11, 32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFF9,   0, "rem_m7_0");
    run_op(0, 2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,   0, "div_ovf");
    run_op(0, 2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h0,           0, "rem_ovf");
    run_op(0, 2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h0,           0, "divu_min_max");
    run_op(0, 2'b00, 32'hFFFF_FFFF,  32'd1,          1'b1, 32'hFFFF_FFFF,   0, "divu_max_1");
    run_op(0, 2'b10, 32'hFFFF_FFFF,  32'd1,          1'b1, 32'h0,           0, "remu_max_1");
    run_op(0, 2'b00, 32'd1000,       32'd10,         1'b1, 32'd100,         5, "divu_hold");
    run_op(1, 2'b01, 32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFF2,   0, "div_m100_7_s2");
    run_op(2, 2'b11, 32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFFE,   0, "rem_m100_7_s4");

    start_only(0, 2'b00, 32'd12345678, 32'd3);
    repeat (10) @(posedge core_clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_busy", {31'h0, bsy[0]}, 32'h0);
    chk("async_reset_ready", {31'h0, rdy[0]}, 32'h0);
    chk("async_reset_result", res[0], 32'h0);
    @(negedge core_clk);
    rst = 1'b0;

    start_only(0, 2'b01, 32'd12345678, 32'd3);
    repeat (10) @(posedge core_clk);
    @(negedge core_clk);
    fl[0] = 1'b1;
    en[0] = 1'b1;
    @(posedge core_clk);
    #1;
    chk("flush_busy", {31'h0, bsy[0]}, 32'h0);
    chk("flush_ready", {31'h0, rdy[0]}, 32'h0);
    fl[0] = 1'b0;
    en[0] = 1'b0;
    run_op(0, 2'b00, 32'hFFFF_FFFF, 32'd3, 1'b1, 32'h5555_5555, 0, "divu_after_flush");

    for (int k = 0; k < 3; k++) begin
      reps = (k == 0) ? 10 : 60;
      for (int o = 0; o < 4; o++) begin
        for (int i = 0; i < reps; i++) begin
          va = $urandom;
          vb = $urandom;
          case (i % 8)
            0: vb = 32'h0;
            1: vb = 32'h1;
            2: vb = 32'hFFFF_FFFF;
            3: va = 32'h8000_0000;
            4: vb = 32'($urandom_range(1, 15));
            5: begin va = 32'h8000_0000; vb = 32'hFFFF_FFFF; end
            default: ;
          endcase
          run_op(k, 2'(o), va, vb, 1'b0, 32'h0, 0, $sformatf("rand_u%0d_op%0d", k, o));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
